encoder_arb: RTL and testbench



---
 rtl/encoder_arb.sv | 104 ++++++++++
 tb/tb_encoder_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/encoder_arb.sv
// Registered priority / round-robin arbiter for single-cycle channel events.
// Events stay pending until their grant is consumed over a valid/ready handshake.
module encoder_arb #(
   parameter int N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         mode,
   input  logic         out_ready,
   input  logic         drop_clr,
   output logic         out_valid,
   output logic [W-1:0] out_num,
   output logic [7:0]   drop_cnt
);

   logic [N-1:0] pending_q, pending_d;
   logic         outValid_q, outValid_d;
   logic [W-1:0] outNum_q, outNum_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic [7:0]   dropCnt_q, dropCnt_d;

   logic         hs;
   logic         load;
   logic         dropEvent;
   logic [N-1:0] consumedMask;
   logic [N-1:0] cand;
   logic [W-1:0] ptrNext;
   logic [W-1:0] sel;
   logic         found;
   int           idx;

   // A request on the bit being consumed re-pends it, so set wins over clear.
   always_comb begin
      hs           = outValid_q & out_ready;
      load         = ~outValid_q | hs;
      consumedMask = hs ? (N'(1) << outNum_q) : '0;
      cand         = (pending_q & ~consumedMask) | req;
      pending_d    = cand;
      dropEvent    = |(req & pending_q & ~consumedMask);
      if (hs) begin
         ptrNext = (outNum_q == W'(N - 1)) ? '0 : outNum_q + 1'b1;
      end else begin
         ptrNext = ptr_q;
      end
   end

   // Scan from 0 in fixed mode, or from the rotating pointer in round-robin mode.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = mode ? (int'(ptrNext) + k) : k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = W'(idx);
         end
      end
   end

   always_comb begin
      outValid_d = outValid_q;
      outNum_d   = outNum_q;
      ptr_d      = hs ? ptrNext : ptr_q;
      dropCnt_d  = dropCnt_q;
      if (load) begin
         outValid_d = found;
         if (found) begin
            outNum_d = sel;
         end
      end
      if (drop_clr) begin
         dropCnt_d = '0;
      end else if (dropEvent && dropCnt_q != 8'hFF) begin
         dropCnt_d = dropCnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= '0;
         outValid_q <= 1'b0;
         outNum_q   <= '0;
         ptr_q      <= '0;
         dropCnt_q  <= '0;
      end else begin
         pending_q  <= pending_d;
         outValid_q <= outValid_d;
         outNum_q   <= outNum_d;
         ptr_q      <= ptr_d;
         dropCnt_q  <= dropCnt_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_num   = outNum_q;
   assign drop_cnt  = dropCnt_q;

endmodule

// File: tb/tb_encoder_arb.sv
// Directed bench for encoder_arb: N=4 for the main scenarios, N=2 and N=32 for width corners.
module tb_encoder_arb;

   logic clk;
   logic rst_n;

   logic [3:0]  req4;
   logic        mode4, ready4, clr4;
   logic        valid4;
   logic [1:0]  num4;
   logic [7:0]  drop4;

   logic [1:0]  req2;
   logic        mode2, ready2, clr2;
   logic        valid2;
   logic [0:0]  num2;
   logic [7:0]  drop2;

   logic [31:0] req32;
   logic        mode32, ready32, clr32;
   logic        valid32;
   logic [4:0]  num32;
   logic [7:0]  drop32;

   int testsRun    = 0;
   int testsFailed = 0;

   encoder_arb #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req(req4), .mode(mode4), .out_ready(ready4),
      .drop_clr(clr4), .out_valid(valid4), .out_num(num4), .drop_cnt(drop4)
   );

   encoder_arb #(.N(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req(req2), .mode(mode2), .out_ready(ready2),
      .drop_clr(clr2), .out_valid(valid2), .out_num(num2), .drop_cnt(drop2)
   );

   encoder_arb #(.N(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .req(req32), .mode(mode32), .out_ready(ready32),
      .drop_clr(clr32), .out_valid(valid32), .out_num(num32), .drop_cnt(drop32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int rrExp[6] = '{0, 1, 2, 3, 0, 1};

      rst_n = 1'b0;
      req4 = '0;  mode4 = 1'b0;  ready4 = 1'b0;  clr4 = 1'b0;
      req2 = '0;  mode2 = 1'b0;  ready2 = 1'b0;  clr2 = 1'b0;
      req32 = '0; mode32 = 1'b0; ready32 = 1'b0; clr32 = 1'b0;
      applyStimulus(2);
      checkOutput("reset_valid", int'(valid4), 0);
      checkOutput("reset_num", int'(num4), 0);
      checkOutput("reset_drop", int'(drop4), 0);
      rst_n = 1'b1;

      // Fixed priority: 1010 grants 1 then 3 then idles
      mode4 = 1'b0; ready4 = 1'b1; req4 = 4'b1010;
      applyStimulus(1);
      req4 = '0;
      checkOutput("fp_first_valid", int'(valid4), 1);
      checkOutput("fp_first_num", int'(num4), 1);
      applyStimulus(1);
      checkOutput("fp_second_num", int'(num4), 3);
      applyStimulus(1);
      checkOutput("fp_idle_valid", int'(valid4), 0);
      checkOutput("fp_drop", int'(drop4), 0);

      // Backpressure: grant of 2 held stable, repeated req counts as a drop
      ready4 = 1'b0; req4 = 4'b0100;
      applyStimulus(1);
      req4 = '0;
      for (int c = 0; c < 5; c++) begin
         checkOutput("bp_hold_valid", int'(valid4), 1);
         checkOutput("bp_hold_num", int'(num4), 2);
         applyStimulus(1);
      end
      req4 = 4'b0100;
      applyStimulus(1);
      req4 = '0;
      checkOutput("bp_drop", int'(drop4), 1);
      checkOutput("bp_still_num", int'(num4), 2);
      ready4 = 1'b1;
      applyStimulus(1);
      checkOutput("bp_after_hs_valid", int'(valid4), 0);
      clr4 = 1'b1;
      applyStimulus(1);
      clr4 = 1'b0;
      checkOutput("bp_clr", int'(drop4), 0);

      // Same-cycle consume and re-request of channel 1
      ready4 = 1'b0; req4 = 4'b0010;
      applyStimulus(1);
      req4 = '0;
      applyStimulus(1);
      checkOutput("sc_held_num", int'(num4), 1);
      ready4 = 1'b1; req4 = 4'b0010;
      applyStimulus(1);
      req4 = '0;
      checkOutput("sc_regrant_valid", int'(valid4), 1);
      checkOutput("sc_regrant_num", int'(num4), 1);
      checkOutput("sc_no_drop", int'(drop4), 0);
      applyStimulus(1);
      checkOutput("sc_drained", int'(valid4), 0);

      // Reset mid-stream with a held grant and 0110 pending
      ready4 = 1'b0; req4 = 4'b0110;
      applyStimulus(1);
      applyStimulus(1);
      req4 = '0;
      checkOutput("mr_pre_valid", int'(valid4), 1);
      checkOutput("mr_pre_drop", int'(drop4), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("mr_async_valid", int'(valid4), 0);
      checkOutput("mr_async_num", int'(num4), 0);
      checkOutput("mr_async_drop", int'(drop4), 0);
      applyStimulus(1);
      rst_n = 1'b1;
      ready4 = 1'b1;
      applyStimulus(3);
      checkOutput("mr_no_ghost", int'(valid4), 0);

      // Round-robin with all requests held, then fixed priority
      mode4 = 1'b1; req4 = 4'b1111;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1);
         checkOutput("rr_seq", int'(num4), rrExp[c]);
      end
      checkOutput("rr_drop5", int'(drop4), 5);
      mode4 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1);
         checkOutput("fp_all_num", int'(num4), 0);
      end
      applyStimulus(260);
      checkOutput("drop_sat", int'(drop4), 255);
      clr4 = 1'b1;
      applyStimulus(1);
      clr4 = 1'b0;
      req4 = '0;
      checkOutput("drop_clr_prio", int'(drop4), 0);
      applyStimulus(1);
      checkOutput("drain_num1", int'(num4), 1);
      applyStimulus(3);
      checkOutput("drain_done", int'(valid4), 0);

      // Width corners: highest index, then pointer wrap back to 0
      mode2 = 1'b1; ready2 = 1'b1; req2 = 2'b10;
      mode32 = 1'b1; ready32 = 1'b1; req32 = 32'h8000_0000;
      applyStimulus(1);
      req2 = '0; req32 = '0;
      checkOutput("n2_top_valid", int'(valid2), 1);
      checkOutput("n2_top_num", int'(num2), 1);
      checkOutput("n32_top_valid", int'(valid32), 1);
      checkOutput("n32_top_num", int'(num32), 31);
      applyStimulus(1);
      checkOutput("n2_idle", int'(valid2), 0);
      checkOutput("n32_idle", int'(valid32), 0);
      req2 = 2'b11; req32 = 32'hFFFF_FFFF;
      applyStimulus(1);
      req2 = '0; req32 = '0;
      checkOutput("n2_wrap_num", int'(num2), 0);
      checkOutput("n32_wrap_num", int'(num32), 0);
      applyStimulus(1);
      checkOutput("n32_next_num", int'(num32), 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
